// File: rtl/i2c_reg_target.sv
// I2C register-write target: oversamples SCL/SDA on clk and turns each data byte into a reg_valid strobe.
// Optional read support is compiled in with `define I2C_REG_TARGET_READ_EN.
module i2c_reg_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h1A
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_data,
   output logic       reg_valid,
   output logic       busy,
   input  logic [7:0] rd_data,
   output logic       rd_strobe
);

   // state     | meaning
   // IDLE      | bus free, waiting for START
   // ADDR      | shifting in address + R/W
   // ADDR_ACK  | driving ACK for our address
   // REG       | shifting in register pointer
   // REG_ACK   | driving ACK for pointer byte
   // DATA      | shifting in write data
   // DATA_ACK  | driving ACK for data byte, pointer++ on release
   // IGNORE    | not for us, wait for START/STOP
   // RDATA     | driving read byte MSB-first (reads only)
   // RACK      | sampling controller ACK/NACK (reads only)
   localparam logic [3:0] ST_IDLE     = 4'd0;
   localparam logic [3:0] ST_ADDR     = 4'd1;
   localparam logic [3:0] ST_ADDR_ACK = 4'd2;
   localparam logic [3:0] ST_REG      = 4'd3;
   localparam logic [3:0] ST_REG_ACK  = 4'd4;
   localparam logic [3:0] ST_DATA     = 4'd5;
   localparam logic [3:0] ST_DATA_ACK = 4'd6;
   localparam logic [3:0] ST_IGNORE   = 4'd7;
`ifdef I2C_REG_TARGET_READ_EN
   localparam logic [3:0] ST_RDATA    = 4'd8;
   localparam logic [3:0] ST_RACK     = 4'd9;
`endif

   logic       scl_meta, scl_sync, scl_hist;
   logic       sda_meta, sda_sync, sda_hist;
   logic [3:0] state;
   logic [2:0] bit_cnt;
   logic [7:0] shift;
   logic [7:0] ptr;
   logic       sda_low;
   logic       phase;

   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] shift_nx;
   logic       addr_match;

   assign i2c_sda    = sda_low ? 1'b0 : 1'bz;
   assign scl_rise   = scl_sync & ~scl_hist;
   assign scl_fall   = ~scl_sync & scl_hist;
   assign start_det  = scl_sync & scl_hist & sda_hist & ~sda_sync;
   assign stop_det   = scl_sync & scl_hist & ~sda_hist & sda_sync;
   assign shift_nx   = {shift[6:0], sda_sync};
   assign addr_match = (shift_nx[7:1] == TARGET_ADDR);

`ifdef I2C_REG_TARGET_READ_EN
   logic       rw;
   logic [7:0] tx;
   logic       rd_pulse;
   assign rd_strobe = rd_pulse;
`else
   logic unused_rd;
   assign unused_rd = ^rd_data;
   assign rd_strobe = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_meta  <= 1'b1;
         scl_sync  <= 1'b1;
         scl_hist  <= 1'b1;
         sda_meta  <= 1'b1;
         sda_sync  <= 1'b1;
         sda_hist  <= 1'b1;
      end else begin
         scl_meta  <= i2c_scl;
         scl_sync  <= scl_meta;
         scl_hist  <= scl_sync;
         sda_meta  <= i2c_sda;
         sda_sync  <= sda_meta;
         sda_hist  <= sda_sync;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         bit_cnt   <= 3'd0;
         shift     <= 8'h00;
         ptr       <= 8'h00;
         sda_low   <= 1'b0;
         phase     <= 1'b0;
         reg_addr  <= 8'h00;
         reg_data  <= 8'h00;
         reg_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef I2C_REG_TARGET_READ_EN
         rw        <= 1'b0;
         tx        <= 8'h00;
         rd_pulse  <= 1'b0;
`endif
      end else begin
         reg_valid <= 1'b0;
`ifdef I2C_REG_TARGET_READ_EN
         rd_pulse  <= 1'b0;
`endif
         if (start_det) begin
            state   <= ST_ADDR;
            bit_cnt <= 3'd0;
            sda_low <= 1'b0;
            phase   <= 1'b0;
         end else if (stop_det) begin
            state   <= ST_IDLE;
            sda_low <= 1'b0;
            phase   <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: if (scl_rise) begin
                  shift   <= shift_nx;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     if (addr_match && !shift_nx[0]) begin
                        state <= ST_ADDR_ACK;
                        busy  <= 1'b1;
`ifdef I2C_REG_TARGET_READ_EN
                        rw    <= 1'b0;
                     end else if (addr_match) begin
                        state    <= ST_ADDR_ACK;
                        busy     <= 1'b1;
                        rw       <= 1'b1;
                        reg_addr <= ptr;
`endif
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end
               end
               ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: if (scl_fall) begin
                  // first falling edge starts the ACK, the second one ends it
                  if (!phase) begin
                     sda_low <= 1'b1;
                     phase   <= 1'b1;
                  end else begin
                     sda_low <= 1'b0;
                     phase   <= 1'b0;
                     bit_cnt <= 3'd0;
                     if (state == ST_ADDR_ACK) begin
                        state <= ST_REG;
`ifdef I2C_REG_TARGET_READ_EN
                        if (rw) begin
                           state    <= ST_RDATA;
                           tx       <= rd_data;
                           sda_low  <= ~rd_data[7];
                           rd_pulse <= 1'b1;
                        end
`endif
                     end else if (state == ST_REG_ACK) begin
                        state <= ST_DATA;
                     end else begin
                        state <= ST_DATA;
                        ptr   <= ptr + 8'd1;
                     end
                  end
               end
               ST_REG: if (scl_rise) begin
                  shift   <= shift_nx;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ptr   <= shift_nx;
                     state <= ST_REG_ACK;
                  end
               end
               ST_DATA: if (scl_rise) begin
                  shift   <= shift_nx;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     reg_data  <= shift_nx;
                     reg_addr  <= ptr;
                     reg_valid <= 1'b1;
                     state     <= ST_DATA_ACK;
                  end
               end
`ifdef I2C_REG_TARGET_READ_EN
               ST_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) phase <= 1'b1;
                  end else if (scl_fall) begin
                     if (phase) begin
                        sda_low <= 1'b0;
                        phase   <= 1'b0;
                        state   <= ST_RACK;
                     end else begin
                        tx      <= {tx[6:0], 1'b0};
                        sda_low <= ~tx[6];
                     end
                  end
               end
               ST_RACK: begin
                  // phase marks "controller ACKed, next byte starts on the fall"
                  if (scl_rise && !phase) begin
                     if (!sda_sync) begin
                        ptr      <= ptr + 8'd1;
                        reg_addr <= ptr + 8'd1;
                        phase    <= 1'b1;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end else if (scl_fall && phase) begin
                     tx       <= rd_data;
                     sda_low  <= ~rd_data[7];
                     rd_pulse <= 1'b1;
                     phase    <= 1'b0;
                     bit_cnt  <= 3'd0;
                     state    <= ST_RDATA;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule
